param_comp: RTL and testbench
=============================

PARAM_COMP -- requirements
Module: param_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, hit-counter width in bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port ld_crux, input, 1, load crux register from crux_in.
REQ-006 SHALL have port crux_in, input, WIDTH, new reference value.
REQ-007 SHALL have port mode, input, 2, compare op: 00 EQ, 01 GT, 10 LT, 11 NE.
REQ-008 SHALL have port in_valid, input, 1, x and mode valid this cycle.
REQ-009 SHALL have port x, input, WIDTH, sample operand.
REQ-010 SHALL have port clr_cnt, input, 1, synchronous clear of hit_cnt.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port result, output, 1, registered compare outcome (x op crux).
REQ-013 SHALL have port hit_cnt, output, CNT_W, saturating count of hits.
REQ-014 SHALL have port streak, output, 1, high while 3 or more consecutive valid hits.

Function
REQ-015 SHALL compare x against the internal crux register as unsigned WIDTH-bit values.
REQ-016 SHALL update crux from crux_in on a clock edge with ld_crux=1; ld_crux=0 holds crux.
REQ-017 SHALL, when ld_crux and in_valid coincide, compare that sample against the old crux; the new crux applies from the next cycle.
REQ-018 SHALL sample mode together with x only on in_valid=1; mode is ignored otherwise.
REQ-019 SHALL register result and out_valid with latency exactly 1 cycle: out_valid(t+1)=in_valid(t).
REQ-020 SHALL, on cycles with in_valid=0, drive out_valid=0 and hold result at its last value.
REQ-021 SHALL define a hit as a valid sample whose compare outcome is 1.
REQ-022 SHALL increment hit_cnt by 1 per hit, in the same edge that registers result.
REQ-023 SHALL saturate hit_cnt at 2^CNT_W-1; further hits leave it unchanged (no wrap).
REQ-024 SHALL give clr_cnt priority: clr_cnt=1 forces hit_cnt=0 even if a hit occurs that cycle.
REQ-025 SHALL implement streak FSM states S0, S1, S2, LOCK; streak=1 only in LOCK (Moore, registered).
REQ-026 SHALL transition on a valid hit S0->S1->S2->LOCK, LOCK->LOCK.
REQ-027 SHALL transition on a valid miss from any state to S0.
REQ-028 SHALL hold FSM state on in_valid=0; gaps do not break a streak.
REQ-029 SHALL update FSM state in the same edge as result, so streak rises together with the third consecutive hit's out_valid.
REQ-030 SHALL not affect FSM state with clr_cnt.
REQ-031 SHALL be synthesizable for WIDTH 1..32 and CNT_W 1..16 with no other changes.

Reset
REQ-032 SHALL, on rst=1, asynchronously set crux=0, result=0, out_valid=0, hit_cnt=0, streak=0, FSM=S0.
REQ-033 SHALL discard any sample in flight when rst asserts mid-operation; no out_valid follows its release.
REQ-034 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-035 SHALL cover EQ sweep: WIDTH=3, load crux=3, mode=00, x=0..7 one per cycle -> result=1 only for x=3, one cycle later; hit_cnt=1.
REQ-036 SHALL cover GT/LT/NE sweep with crux=3 -> GT hits x=4..7 (hit_cnt=4); LT hits x=0..2 (3); NE hits 7 of 8 values.
REQ-037 SHALL cover saturation: CNT_W=4, mode=NE, crux=0, 20 hits of x=5 -> hit_cnt reaches 15 and stays 15; clr_cnt with a hit same cycle -> hit_cnt=0.
REQ-038 SHALL cover crux collision: crux=3, same cycle ld_crux=1 crux_in=5, in_valid=1 x=3 mode=EQ -> result=1; next x=3 -> result=0, x=5 -> result=1.
REQ-039 SHALL cover streak: EQ crux=3, x=3,3,idle,3,3,4 -> streak rises with third hit's out_valid, stays high with fourth, falls after x=4.
REQ-040 SHALL cover reset mid-operation: rst pulse asynchronously between edges while in LOCK with hit_cnt=7 -> all outputs 0 immediately, crux=0, no out_valid until a new in_valid.

Source files
------------

// File: rtl/param_comp.sv
// ---------------------------------------------------------------------------
// param_comp
//   Compares a sample operand x against a loadable reference register (crux)
//   with a selectable unsigned operator. Produces a registered result one
//   cycle after each valid sample, a saturating count of hits and a streak
//   flag that is high once three or more consecutive valid samples hit.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous, active-high reset
//   ld_crux   : load crux from crux_in on this edge
//   crux_in   : new reference value (WIDTH)
//   mode      : 00 EQ, 01 GT, 10 LT, 11 NE (sampled with x on in_valid)
//   in_valid  : x and mode are valid this cycle
//   x         : sample operand (WIDTH)
//   clr_cnt   : synchronous clear of hit_cnt, wins over a same-cycle hit
//   out_valid : result valid, in_valid delayed by one cycle
//   result    : registered outcome of (x op crux), held while idle
//   hit_cnt   : saturating number of hits (CNT_W)
//   streak    : high while in LOCK (three or more consecutive hits)
//
// Handshake: in_valid is a one-cycle qualifier with no backpressure; every
// cycle with in_valid=1 produces exactly one out_valid=1 cycle one edge later.
// ---------------------------------------------------------------------------
module param_comp #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_crux,
   input  logic [WIDTH-1:0] crux_in,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] x,
   input  logic             clr_cnt,
   output logic             out_valid,
   output logic             result,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             streak
);

   typedef enum logic [1:0] {
      S0   = 2'd0,
      S1   = 2'd1,
      S2   = 2'd2,
      LOCK = 2'd3
   } state_t;

   localparam logic [1:0] MODE_EQ = 2'b00;
   localparam logic [1:0] MODE_GT = 2'b01;
   localparam logic [1:0] MODE_LT = 2'b10;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] crux;
   state_t           state;
   logic             cmp;
   logic             hit;

   // Compare uses the crux value registered before this edge, so a load in
   // the same cycle only affects later samples.
   always_comb begin
      cmp = 1'b0;
      case (mode)
         MODE_EQ: cmp = (x == crux);
         MODE_GT: cmp = (x >  crux);
         MODE_LT: cmp = (x <  crux);
         default: cmp = (x != crux);
      endcase
   end

   assign hit = in_valid & cmp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crux <= '0;
      end else if (ld_crux) begin
         crux <= crux_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            result <= cmp;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt <= '0;
      end else if (clr_cnt) begin
         hit_cnt <= '0;
      end else if (hit && (hit_cnt != CNT_MAX)) begin
         hit_cnt <= hit_cnt + 1'b1;
      end
   end

   // Streak FSM: idle cycles hold the state, a valid miss restarts it.
   // streak is registered alongside the state so it is high exactly in LOCK.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S0;
         streak <= 1'b0;
      end else if (in_valid) begin
         if (cmp) begin
            case (state)
               S0:      begin state <= S1;   streak <= 1'b0; end
               S1:      begin state <= S2;   streak <= 1'b0; end
               default: begin state <= LOCK; streak <= 1'b1; end
            endcase
         end else begin
            state  <= S0;
            streak <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_param_comp.sv
// ---------------------------------------------------------------------------
// tb_param_comp
//   Self-checking bench for param_comp (WIDTH=3, CNT_W=4). A behavioural
//   model tracks crux, the hit count and the length of the current run of
//   consecutive hits; every cycle the DUT outputs are compared with it.
//   Results of valid samples are queued and popped when out_valid appears.
// ---------------------------------------------------------------------------
module tb_param_comp;

   localparam int W  = 3;
   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          ld_crux;
   logic [W-1:0]  crux_in;
   logic [1:0]    mode;
   logic          in_valid;
   logic [W-1:0]  x;
   logic          clr_cnt;
   logic          out_valid;
   logic          result;
   logic [CW-1:0] hit_cnt;
   logic          streak;

   param_comp #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_crux   (ld_crux),
      .crux_in   (crux_in),
      .mode      (mode),
      .in_valid  (in_valid),
      .x         (x),
      .clr_cnt   (clr_cnt),
      .out_valid (out_valid),
      .result    (result),
      .hit_cnt   (hit_cnt),
      .streak    (streak)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard / model state
   int          n_checks = 0;
   int          n_errors = 0;
   logic [0:0]  exp_q[$];
   int          m_crux;
   int          m_hits;
   int          m_run;
   int          m_res;
   int          m_ov;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int op(input int m, input int a, input int b);
      case (m)
         0:       return (a == b) ? 1 : 0;
         1:       return (a >  b) ? 1 : 0;
         2:       return (a <  b) ? 1 : 0;
         default: return (a != b) ? 1 : 0;
      endcase
   endfunction

   task automatic model_reset();
      m_crux = 0; m_hits = 0; m_run = 0; m_res = 0; m_ov = 0;
      exp_q.delete();
   endtask

   task automatic check_outputs(input string tag);
      logic [0:0] e;
      check({tag, ".out_valid"}, out_valid, m_ov);
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check({tag, ".unexpected_valid"}, 1, 0);
         end else begin
            e = exp_q.pop_front();
            check({tag, ".result"}, result, e);
         end
      end else begin
         check({tag, ".result_hold"}, result, m_res);
      end
      check({tag, ".hit_cnt"}, hit_cnt, m_hits);
      check({tag, ".streak"}, streak, (m_run >= 3) ? 1 : 0);
   endtask

   // driver: apply one cycle of inputs, advance the model at the edge, check
   task automatic cyc(input string tag, input logic ld, input int ci, input int m,
                      input logic v, input int xv, input logic clr);
      int r;
      ld_crux  = ld;
      crux_in  = ci[W-1:0];
      mode     = m[1:0];
      in_valid = v;
      x        = xv[W-1:0];
      clr_cnt  = clr;
      @(posedge clk);
      if (v) begin
         r     = op(m, xv, m_crux);
         m_res = r;
         exp_q.push_back(r[0:0]);
         if (r != 0) begin
            if (m_hits < CNT_MAX) m_hits++;
            m_run++;
         end else begin
            m_run = 0;
         end
      end
      m_ov = v;
      if (clr) m_hits = 0;
      if (ld) m_crux = ci;
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 1'b0, 0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic sweep(input string tag, input int m, input int exp_hits);
      cyc({tag, ".clr"}, 1'b0, 0, m, 1'b0, 0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cyc(tag, 1'b0, 0, m, 1'b1, i, 1'b0);
      end
      idle({tag, ".tail"});
      check({tag, ".total_hits"}, hit_cnt, exp_hits);
   endtask

   initial begin
      ld_crux = 0; crux_in = 0; mode = 0; in_valid = 0; x = 0; clr_cnt = 0;
      rst = 1'b1;
      model_reset();
      #1;
      check("reset.out_valid", out_valid, 0);
      check("reset.result", result, 0);
      check("reset.hit_cnt", hit_cnt, 0);
      check("reset.streak", streak, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;

      // operator sweeps against crux=3
      cyc("ld3", 1'b1, 3, 0, 1'b0, 0, 1'b0);
      sweep("eq", 0, 1);
      sweep("gt", 1, 4);
      sweep("lt", 2, 3);
      sweep("ne", 3, 7);

      // saturation and clear priority
      cyc("ld0", 1'b1, 0, 3, 1'b0, 0, 1'b1);
      for (int i = 0; i < 20; i++) cyc("sat", 1'b0, 0, 3, 1'b1, 5, 1'b0);
      check("sat.max", hit_cnt, 15);
      cyc("clr_hit", 1'b0, 0, 3, 1'b1, 5, 1'b1);
      check("clr_hit.zero", hit_cnt, 0);

      // load/compare collision
      cyc("col.ld3", 1'b1, 3, 0, 1'b0, 0, 1'b0);
      cyc("col.same", 1'b1, 5, 0, 1'b1, 3, 1'b0);
      check("col.old_crux", result, 1);
      cyc("col.x3", 1'b0, 0, 0, 1'b1, 3, 1'b0);
      check("col.new_crux_miss", result, 0);
      cyc("col.x5", 1'b0, 0, 0, 1'b1, 5, 1'b0);
      check("col.new_crux_hit", result, 1);

      // streak: 3,3,idle,3,3,4
      cyc("stk.ld3", 1'b1, 3, 0, 1'b0, 0, 1'b0);
      cyc("stk.miss", 1'b0, 0, 0, 1'b1, 0, 1'b0);
      cyc("stk.h1", 1'b0, 0, 0, 1'b1, 3, 1'b0);
      cyc("stk.h2", 1'b0, 0, 0, 1'b1, 3, 1'b0);
      idle("stk.gap");
      check("stk.gap_low", streak, 0);
      cyc("stk.h3", 1'b0, 0, 0, 1'b1, 3, 1'b0);
      check("stk.rise", streak, 1);
      cyc("stk.h4", 1'b0, 0, 0, 1'b1, 3, 1'b0);
      check("stk.stay", streak, 1);
      cyc("stk.m", 1'b0, 0, 0, 1'b1, 4, 1'b0);
      check("stk.fall", streak, 0);

      // reset mid-operation from LOCK with hit_cnt=7 and a sample pending
      cyc("rmo.clr", 1'b0, 0, 0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 7; i++) cyc("rmo.hit", 1'b0, 0, 0, 1'b1, 3, 1'b0);
      check("rmo.pre_cnt", hit_cnt, 7);
      check("rmo.pre_streak", streak, 1);
      in_valid = 1'b1; x = 3;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("rmo.out_valid", out_valid, 0);
      check("rmo.result", result, 0);
      check("rmo.hit_cnt", hit_cnt, 0);
      check("rmo.streak", streak, 0);
      in_valid = 1'b0;
      #1 rst = 1'b0;
      idle("rmo.release");
      cyc("rmo.crux0", 1'b0, 0, 0, 1'b1, 0, 1'b0);
      check("rmo.crux_is_0", result, 1);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cyc("rand",
             ($urandom_range(0, 7) == 0),
             $urandom_range(0, (1 << W) - 1),
             $urandom_range(0, 3),
             ($urandom_range(0, 3) != 0),
             $urandom_range(0, (1 << W) - 1),
             ($urandom_range(0, 15) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
